// File: rtl/cart_bus_master_if.sv
// Host request/response handshake plus cartridge pad signals for cart_bus_master.
// The master modport is the bus-master block's view; slave is the host/pad side.
interface cart_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [14:0] bus_adr;
    logic        bus_a15;
    logic        bus_n_cs;
    logic        bus_n_rd;
    logic        bus_n_wr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_data_in,
        output req_ready, rsp_valid, rsp_rdata,
        output bus_adr, bus_a15, bus_n_cs, bus_n_rd, bus_n_wr, bus_data_out, bus_data_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_data_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  bus_adr, bus_a15, bus_n_cs, bus_n_rd, bus_n_wr, bus_data_out, bus_data_oe
    );
endinterface

// File: rtl/cart_bus_master.sv
// Cartridge bus master: turns one host request into an 8-phase cartridge bus cycle
// of PHASE_TICKS clocks per phase, with every pad output driven from a register.
module cart_bus_master #(
    parameter int PHASE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    cart_bus_master_if.master  bus
);
    localparam int            TW       = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(PHASE_TICKS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tick, w_tick_next;
    logic [2:0]    r_phase, w_phase_next;
    logic          r_write, w_write_next;
    logic [15:0]   r_addr, w_addr_next;
    logic [7:0]    r_wdata, w_wdata_next;
    logic          r_rsp_valid, w_rsp_valid_next;
    logic [7:0]    r_rdata, w_rdata_next;
    logic          r_a15, w_a15_next;
    logic          r_n_cs, w_n_cs_next;
    logic          r_n_rd, w_n_rd_next;
    logic          r_n_wr, w_n_wr_next;
    logic          r_oe, w_oe_next;
    logic [7:0]    r_dout, w_dout_next;
    logic          w_tick_last;
    logic          w_run;

    assign w_tick_last = (r_tick == TICK_MAX);

    always_comb begin
        w_state_next     = r_state;
        w_tick_next      = r_tick;
        w_phase_next     = r_phase;
        w_write_next     = r_write;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_rsp_valid_next = 1'b0;
        w_rdata_next     = r_rdata;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = RUN;
                    w_tick_next  = '0;
                    w_phase_next = 3'd0;
                    w_write_next = bus.req_write;
                    w_addr_next  = bus.req_addr;
                    w_wdata_next = bus.req_wdata;
                end
            end
            RUN: begin
                if (w_tick_last) begin
                    w_tick_next = '0;
                    if (r_phase == 3'd7) begin
                        // Final clock of phase 7: sample the pad and hand back to the host.
                        w_state_next     = IDLE;
                        w_phase_next     = 3'd0;
                        w_rsp_valid_next = 1'b1;
                        if (!r_write) begin
                            w_rdata_next = bus.bus_data_in;
                        end
                    end else begin
                        w_phase_next = r_phase + 3'd1;
                    end
                end else begin
                    w_tick_next = r_tick + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Pad levels are decoded from the next state so the registers change exactly
        // on phase boundaries.
        w_run       = (w_state_next == RUN);
        w_a15_next  = !(w_run && (w_phase_next >= 3'd2) && !w_addr_next[15]);
        w_n_cs_next = !(w_run && (w_phase_next >= 3'd2) && (w_addr_next[15:13] == 3'b101));
        w_n_rd_next = !(w_run && !w_write_next);
        w_n_wr_next = !(w_run && w_write_next && (w_phase_next >= 3'd4) && (w_phase_next <= 3'd6));
        w_oe_next   = w_run && w_write_next && (w_phase_next >= 3'd3);
        w_dout_next = w_oe_next ? w_wdata_next : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_phase     <= 3'd0;
            r_write     <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'h00;
            r_a15       <= 1'b1;
            r_n_cs      <= 1'b1;
            r_n_rd      <= 1'b1;
            r_n_wr      <= 1'b1;
            r_oe        <= 1'b0;
            r_dout      <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_phase     <= w_phase_next;
            r_write     <= w_write_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rdata     <= w_rdata_next;
            r_a15       <= w_a15_next;
            r_n_cs      <= w_n_cs_next;
            r_n_rd      <= w_n_rd_next;
            r_n_wr      <= w_n_wr_next;
            r_oe        <= w_oe_next;
            r_dout      <= w_dout_next;
        end
    end

    assign bus.req_ready    = (r_state == IDLE);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rdata;
    assign bus.bus_adr      = r_addr[14:0];
    assign bus.bus_a15      = r_a15;
    assign bus.bus_n_cs     = r_n_cs;
    assign bus.bus_n_rd     = r_n_rd;
    assign bus.bus_n_wr     = r_n_wr;
    assign bus.bus_data_oe  = r_oe;
    assign bus.bus_data_out = r_dout;
endmodule

// File: tb/tb_cart_bus_master.sv
// Scoreboard bench for cart_bus_master: directed requests queue their expected bus
// profile and read data; a negedge monitor measures each cycle and checks on rsp_valid.
module tb_cart_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cart_bus_master_if bif();
    cart_bus_master_if bif1();

    cart_bus_master #(.PHASE_TICKS(4)) dut  (.clk(clk), .rst(rst), .bus(bif));
    cart_bus_master #(.PHASE_TICKS(1)) dut1 (.clk(clk), .rst(rst), .bus(bif1));

    // Cartridge pad model: data returned depends on the address on the pins.
    function automatic logic [7:0] pad(input logic [14:0] a);
        case (a)
            15'h0134: return 8'hCE;
            15'h2000: return 8'h5A;
            15'h4000: return 8'h3C;
            15'h0100: return 8'h11;
            15'h0101: return 8'h22;
            default:  return 8'hE7;
        endcase
    endfunction
    assign bif.bus_data_in  = pad(bif.bus_adr);
    assign bif1.bus_data_in = pad(bif1.bus_adr);

    typedef struct {
        logic [7:0]  rdata;
        int          lat, rd_lo, wr_lo, a15_lo, cs_lo, oe_hi;
        logic [14:0] adr;
        bit          b2b;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pad activity per transaction, checks when rsp_valid appears.
    initial begin
        bit          m_active = 0;
        bit          m_b2b = 0;
        int          m_lat = 0, m_rd = 0, m_wr = 0, m_a15 = 0, m_cs = 0, m_oe = 0, m_viol = 0;
        logic [14:0] m_adr = '0;
        logic [7:0]  m_wdata = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 0;
            end else begin
                if (m_active) begin
                    m_lat++;
                    if (m_lat == 1) m_adr = bif.bus_adr;
                    if (!bif.bus_n_rd) m_rd++;
                    if (!bif.bus_n_wr) m_wr++;
                    if (!bif.bus_a15)  m_a15++;
                    if (!bif.bus_n_cs) m_cs++;
                    if (bif.bus_data_oe) m_oe++;
                    if ((bif.bus_data_oe && bif.bus_data_out != m_wdata) ||
                        (!bif.bus_n_wr && !bif.bus_data_oe) ||
                        (!bif.bus_n_rd && (!bif.bus_n_wr || bif.bus_data_oe)))
                        m_viol++;
                end
                if (bif.rsp_valid) begin
                    if (!m_active || sb.size() == 0) begin
                        chk("unexpected_rsp_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("t%0d rsp_rdata", txn), int'(bif.rsp_rdata), int'(e.rdata));
                        chk($sformatf("t%0d latency", txn), m_lat, e.lat);
                        chk($sformatf("t%0d n_rd_low_clks", txn), m_rd, e.rd_lo);
                        chk($sformatf("t%0d n_wr_low_clks", txn), m_wr, e.wr_lo);
                        chk($sformatf("t%0d a15_low_clks", txn), m_a15, e.a15_lo);
                        chk($sformatf("t%0d n_cs_low_clks", txn), m_cs, e.cs_lo);
                        chk($sformatf("t%0d oe_high_clks", txn), m_oe, e.oe_hi);
                        chk($sformatf("t%0d bus_adr", txn), int'(m_adr), int'(e.adr));
                        chk($sformatf("t%0d back_to_back", txn), int'(m_b2b), int'(e.b2b));
                        chk($sformatf("t%0d pad_violations", txn), m_viol, 0);
                        $display("txn %0d: adr=0x%04h rdata=0x%02h lat=%0d rd=%0d wr=%0d a15=%0d cs=%0d oe=%0d",
                                 txn, m_adr, bif.rsp_rdata, m_lat, m_rd, m_wr, m_a15, m_cs, m_oe);
                        txn++;
                    end
                    m_active = 0;
                end
                if (bif.req_valid && bif.req_ready) begin
                    m_active = 1;
                    m_b2b    = bif.rsp_valid;
                    m_wdata  = bif.req_wdata;
                    m_lat = 0; m_rd = 0; m_wr = 0; m_a15 = 0; m_cs = 0; m_oe = 0; m_viol = 0;
                end
            end
        end
    end

    // Presents a request until accepted; optionally queues its expected response.
    task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] wd, input bit track,
                         input logic [7:0] x_rd, input int rd, input int wlo, input int a15,
                         input int cs, input int oe, input bit b2b);
        exp_t e;
        int   n;
        if (track) begin
            e.rdata = x_rd; e.lat = 33; e.rd_lo = rd; e.wr_lo = wlo; e.a15_lo = a15;
            e.cs_lo = cs; e.oe_hi = oe; e.adr = a[14:0]; e.b2b = b2b;
            sb.push_back(e);
        end
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = a;
        bif.req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.req_ready && n < 200);
        if (!bif.req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        // Scramble the request while the cycle runs; the block must ignore it.
        bif.req_valid = 1'b0;
        bif.req_write = ~wr;
        bif.req_addr  = ~a;
        bif.req_wdata = ~wd;
    endtask

    task automatic idle(input int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bif.req_ready && k < 200);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, rd, a15;
        bif.req_valid = 0; bif.req_write = 0; bif.req_addr = '0; bif.req_wdata = '0;
        bif1.req_valid = 0; bif1.req_write = 0; bif1.req_addr = '0; bif1.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset req_ready", int'(bif.req_ready), 1);
        chk("reset rsp_valid", int'(bif.rsp_valid), 0);
        chk("reset rsp_rdata", int'(bif.rsp_rdata), 0);
        chk("reset bus_adr", int'(bif.bus_adr), 0);
        chk("reset strobes_selects", int'({bif.bus_n_rd, bif.bus_n_wr, bif.bus_a15, bif.bus_n_cs}), 4'hF);
        chk("reset bus_data_oe", int'(bif.bus_data_oe), 0);

        //    wr  addr      wd     trk exp_rd  rd  wr  a15 cs  oe  b2b
        issue(0, 16'h0134, 8'h00, 1, 8'hCE, 32, 0,  24, 0,  0,  0); idle(3);
        issue(1, 16'h2000, 8'h01, 1, 8'hCE, 0,  12, 24, 0,  20, 0); idle(3);
        issue(0, 16'hA000, 8'h00, 1, 8'h5A, 32, 0,  0,  24, 0,  0); idle(3);
        issue(0, 16'hC000, 8'h00, 1, 8'h3C, 32, 0,  0,  0,  0,  0); idle(3);
        issue(0, 16'h0100, 8'h00, 1, 8'h11, 32, 0,  24, 0,  0,  0);
        issue(0, 16'h0101, 8'h00, 1, 8'h22, 32, 0,  24, 0,  0,  1); idle(3);

        // Abort a write in phase 5 (clocks 21..24 after acceptance).
        issue(1, 16'h3000, 8'h77, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        repeat (21) @(posedge clk);
        #1;
        chk("abort pre n_wr", int'(bif.bus_n_wr), 0);
        chk("abort pre oe", int'(bif.bus_data_oe), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort n_wr", int'(bif.bus_n_wr), 1);
        chk("abort oe", int'(bif.bus_data_oe), 0);
        chk("abort req_ready", int'(bif.req_ready), 1);
        chk("abort rsp_valid", int'(bif.rsp_valid), 0);
        chk("abort rsp_rdata", int'(bif.rsp_rdata), 0);
        idle(40);

        issue(0, 16'h0134, 8'h00, 1, 8'hCE, 32, 0, 24, 0, 0, 0); idle(3);

        // PHASE_TICKS=1 instance: same phase pattern in 8 clocks.
        bif1.req_valid = 1'b1; bif1.req_write = 1'b0; bif1.req_addr = 16'h0134;
        @(posedge clk);
        #1;
        bif1.req_valid = 1'b0;
        lat = 0; rd = 0; a15 = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bif1.bus_n_rd) rd++;
            if (!bif1.bus_a15) a15++;
        end while (!bif1.rsp_valid && lat < 50);
        chk("pt1 latency", lat, 9);
        chk("pt1 n_rd_low_clks", rd, 8);
        chk("pt1 a15_low_clks", a15, 6);
        chk("pt1 rsp_rdata", int'(bif1.rsp_rdata), 8'hCE);
        $display("txn pt1: lat=%0d rd=%0d a15=%0d rdata=0x%02h", lat, rd, a15, bif1.rsp_rdata);

        idle(5);
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cart_bus_master.md
CART_BUS_MASTER -- requirements
Module: cart_bus_master

Interface
REQ-001 SHALL have parameter PHASE_TICKS, default 4, meaning clk ticks per bus phase; legal range 1..64.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  host request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  cartridge-side address.
REQ-008 SHALL have port req_wdata  input  8  write byte.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  8  byte captured by the last read.
REQ-011 SHALL have port bus_adr  output  15  cartridge A0-A14.
REQ-012 SHALL have port bus_a15  output  1  A15 / ROM select, active low.
REQ-013 SHALL have port bus_n_cs  output  1  external-RAM select, active low.
REQ-014 SHALL have port bus_n_rd / bus_n_wr  output  1 each  active-low strobes.
REQ-015 SHALL have ports bus_data_out (output, 8), bus_data_oe (output, 1) and bus_data_in (input, 8) for the data pad buffer and direction.

Function
REQ-016 SHALL have states IDLE and RUN; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a clk edge where req_valid && req_ready, latch addr/wdata/write, and enter RUN.
REQ-018 SHALL run each bus cycle as 8 phases (0..7) of PHASE_TICKS clocks each, i.e. 8*PHASE_TICKS clocks; phase 0 starts the cycle after acceptance.
REQ-019 SHALL drive bus_adr = latched addr[14:0] from phase 0, and hold it after the cycle until the next acceptance.
REQ-020 SHALL drive bus_a15 low in phases 2..7 when addr[15]=0, and high otherwise.
REQ-021 SHALL drive bus_n_cs low in phases 2..7 when addr is in 0xA000-0xBFFF, and high otherwise.
REQ-022 Read: SHALL hold bus_n_rd low in phases 0..7, keep bus_n_wr high, and keep bus_data_oe = 0.
REQ-023 Read: SHALL register bus_data_in into rsp_rdata on the final clk of phase 7.
REQ-024 Write: SHALL keep bus_n_rd high, drive bus_data_oe = 1 with bus_data_out = wdata in phases 3..7, and drive bus_n_wr low in phases 4..6.
REQ-025 Write: SHALL leave rsp_rdata unchanged.
REQ-026 SHALL assert rsp_valid for exactly one clk, the first clk after phase 7, in IDLE with req_ready = 1.
REQ-027 SHALL permit a new acceptance in that same clk, so back-to-back cycles have a gap of exactly one clk.
REQ-028 In IDLE, SHALL hold bus_n_rd = bus_n_wr = bus_a15 = bus_n_cs = 1 and bus_data_oe = 0.
REQ-029 All bus outputs SHALL be registered, glitch-free and changing only on phase boundaries.
REQ-030 SHALL size the phase tick counter as ceil(log2(PHASE_TICKS)) bits, minimum 1, and wrap 0..PHASE_TICKS-1.
REQ-031 SHALL ignore req_* changes while in RUN.

Reset
REQ-032 With rst=1, SHALL reach the following at the next edge: state IDLE, counters 0, bus_adr = 0, rsp_rdata = 0, rsp_valid = 0, strobes and selects high, bus_data_oe = 0.
REQ-033 Reset during RUN SHALL abort the cycle with no rsp_valid; the request is lost.
REQ-034 rst SHALL take priority over a simultaneous req_valid.

Verification (PHASE_TICKS=4)
REQ-035 Read 0x0134 with bus_data_in=0xCE -> bus_n_rd low 32 clks, bus_a15 low 24 clks, bus_n_cs high, rsp_rdata=0xCE, rsp_valid 1 clk at acceptance+33.
REQ-036 Write 0x2000 data 0x01 -> bus_n_wr low 12 clks inside a 20-clk bus_data_oe window with bus_data_out=0x01, bus_a15 low 24 clks, bus_n_rd high throughout.
REQ-037 Read 0xA000 -> bus_n_cs low 24 clks, bus_a15 high; read 0xC000 -> both selects high, bus_n_rd low 32 clks.
REQ-038 req_valid held high for two reads (0x0100, 0x0101) -> second phase 0 starts exactly 1 clk after first rsp_valid, and bus_adr changes 0x100 -> 0x101.
REQ-039 rst pulsed in phase 5 of a write -> next clk: bus_n_wr=1, bus_data_oe=0, req_ready=1, no rsp_valid.
REQ-040 PHASE_TICKS=1 -> read completes in 8 clks with the same phase pattern.
